// File: rtl/eight_player.sv
// Player sprite controller: horizontal walking with edge clamps, a
// ballistic jump, chaser collision detection, lives and post-hit immunity.
module eight_player #(
    parameter int unsigned X_START       = 320,
    parameter int unsigned Y_GROUND      = 400,
    parameter int unsigned X_MIN         = 2,
    parameter int unsigned X_MAX         = 637,
    parameter int unsigned X_STEP        = 2,
    parameter int unsigned JUMP_V0       = 12,
    parameter int unsigned HIT_RADIUS    = 8,
    parameter int unsigned INVULN_FRAMES = 60,
    parameter int unsigned LIVES_INIT    = 3
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic [7:0] keycode,
    input  logic [9:0] ismilex,
    input  logic [9:0] ismiley,
    output logic [9:0] eightx,
    output logic [9:0] eighty,
    output logic [1:0] lives,
    output logic       hit,
    output logic       invuln,
    output logic       game_over
);

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    localparam int unsigned CW = (INVULN_FRAMES > 0) ? $clog2(INVULN_FRAMES + 1) : 1;

    localparam logic [9:0]    XSTART_V   = 10'(X_START);
    localparam logic [9:0]    YGND_V     = 10'(Y_GROUND);
    localparam logic [9:0]    XMIN_V     = 10'(X_MIN);
    localparam logic [9:0]    XMAX_V     = 10'(X_MAX);
    localparam logic [9:0]    XSTEP_V    = 10'(X_STEP);
    localparam logic [10:0]   XMAX_W     = 11'(X_MAX);
    localparam logic [10:0]   XSTEP_W    = 11'(X_STEP);
    localparam logic [10:0]   XLEFT_LIM  = 11'(X_MIN + X_STEP);
    localparam logic [10:0]   YGND_W     = 11'(Y_GROUND);
    localparam logic [3:0]    JV0        = 4'(JUMP_V0);
    localparam logic [9:0]    RADIUS     = 10'(HIT_RADIUS);
    localparam logic [CW-1:0] INV_INIT   = CW'(INVULN_FRAMES);
    localparam logic [1:0]    LIVES_V    = 2'(LIVES_INIT);

    typedef enum logic [1:0] {GROUND, RISING, FALLING, DEAD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    vel_q, vel_d;
    logic [9:0]    x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    lives_q, lives_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;

    logic [10:0]   x_ext, x_right, y_fall;
    logic [9:0]    dx, dy;
    logic          collide, counted;

    // State register with synchronous active-low reset
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            state_q <= GROUND;
            vel_q   <= '0;
            x_q     <= XSTART_V;
            y_q     <= YGND_V;
            lives_q <= LIVES_V;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            vel_q   <= vel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
        end
    end

    // Next-state logic: horizontal motion, jump physics and collision bookkeeping
    always_comb begin
        state_d = state_q;
        vel_d   = vel_q;
        x_d     = x_q;
        y_d     = y_q;
        lives_d = lives_q;
        hit_d   = 1'b0;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : '0;

        x_ext   = {1'b0, x_q};
        x_right = x_ext + XSTEP_W;
        y_fall  = {1'b0, y_q} + {7'b0, vel_q};
        dx      = (x_q >= ismilex) ? x_q - ismilex : ismilex - x_q;
        dy      = (y_q >= ismiley) ? y_q - ismiley : ismiley - y_q;
        collide = (dx <= RADIUS) && (dy <= RADIUS);
        counted = collide && (state_q != DEAD) && (cnt_q == '0);

        if (state_q != DEAD) begin
            // Left clamp compares before subtracting so a small x never wraps
            if (keycode == KEY_LEFT) begin
                x_d = (x_ext >= XLEFT_LIM) ? x_q - XSTEP_V : XMIN_V;
            end else if (keycode == KEY_RIGHT) begin
                x_d = (x_right > XMAX_W) ? XMAX_V : x_right[9:0];
            end

            case (state_q)
                GROUND: begin
                    if (keycode == KEY_JUMP) begin
                        state_d = RISING;
                        vel_d   = JV0;
                    end
                end
                RISING: begin
                    y_d = y_q - {6'b0, vel_q};
                    if (vel_q == 4'd1) begin
                        state_d = FALLING;
                        vel_d   = '0;
                    end else begin
                        vel_d = vel_q - 4'd1;
                    end
                end
                FALLING: begin
                    if (y_fall >= YGND_W) begin
                        y_d     = YGND_V;
                        vel_d   = '0;
                        state_d = GROUND;
                    end else begin
                        y_d   = y_fall[9:0];
                        vel_d = (vel_q >= JV0) ? JV0 : vel_q + 4'd1;
                    end
                end
                default: ;
            endcase

            if (counted) begin
                hit_d   = 1'b1;
                lives_d = lives_q - 2'd1;
                cnt_d   = INV_INIT;
                if (lives_q == 2'd1) begin
                    state_d = DEAD;
                end
            end
        end
    end

    // Outputs decoded directly from registers
    always_comb begin
        eightx    = x_q;
        eighty    = y_q;
        lives     = lives_q;
        hit       = hit_q;
        invuln    = (cnt_q != '0);
        game_over = (state_q == DEAD);
    end

endmodule

// File: tb/tb_eight_player.sv
// Directed bench for eight_player: table of per-frame vectors plus
// hand-written jump, immunity, game-over and mid-jump reset sequences.
module tb_eight_player;

    logic       frame_clk;
    logic       Reset;
    logic [7:0] keycode;
    logic [9:0] ismilex, ismiley;
    logic [9:0] eightx, eighty;
    logic [1:0] lives;
    logic       hit, invuln, game_over;

    logic [9:0] s_x, s_y;
    logic [1:0] s_lives;
    logic       s_hit, s_invuln, s_go;

    int tests  = 0;
    int failed = 0;

    eight_player u_dut (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .ismilex(ismilex), .ismiley(ismiley),
        .eightx(eightx), .eighty(eighty), .lives(lives),
        .hit(hit), .invuln(invuln), .game_over(game_over)
    );

    // Second player starting at an odd x near the left edge for the clamp check
    eight_player #(.X_START(5)) u_small (
        .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode),
        .ismilex(ismilex), .ismiley(ismiley),
        .eightx(s_x), .eighty(s_y), .lives(s_lives),
        .hit(s_hit), .invuln(s_invuln), .game_over(s_go)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [7:0]  key;
        logic [9:0]  sx, sy;
        int          n;
        int          ex, ey, el, eh, ei, eg;
    } vec_t;

    vec_t vecs [0:9];

    // y after each edge E1..E25 following a jump press sampled at E0
    int traj [0:24] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322,
                        322, 323, 325, 328, 332, 337, 343, 350, 358, 367, 377, 388, 400};

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input int ex, input int ey, input int el,
                           input int eh, input int ei, input int eg);
        chk($sformatf("%s.x", nm), int'(eightx), ex);
        chk($sformatf("%s.y", nm), int'(eighty), ey);
        chk($sformatf("%s.lives", nm), int'(lives), el);
        chk($sformatf("%s.hit", nm), int'(hit), eh);
        chk($sformatf("%s.invuln", nm), int'(invuln), ei);
        chk($sformatf("%s.game_over", nm), int'(game_over), eg);
    endtask

    task automatic step();
        @(posedge frame_clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        step();
        Reset = 1'b1;
    endtask

    initial begin
        Reset   = 1'b0;
        keycode = 8'h00;
        ismilex = '0;
        ismiley = '0;

        //            name         rst  key    sx   sy   n   x    y   l  h  i  g
        vecs[0] = '{"reset",      1'b0, 8'h00,   0,   0, 2, 320, 400, 3, 0, 0, 0};
        vecs[1] = '{"right10",    1'b1, 8'h07,   0,   0, 10, 340, 400, 3, 0, 0, 0};
        vecs[2] = '{"left3",      1'b1, 8'h04,   0,   0, 3, 334, 400, 3, 0, 0, 0};
        vecs[3] = '{"nohit_dx9",  1'b1, 8'h00, 343, 400, 3, 334, 400, 3, 0, 0, 0};
        vecs[4] = '{"nohit_dy9",  1'b1, 8'h00, 334, 409, 3, 334, 400, 3, 0, 0, 0};
        vecs[5] = '{"hit_dx8",    1'b1, 8'h00, 342, 400, 1, 334, 400, 2, 1, 1, 0};
        vecs[6] = '{"hit_clear",  1'b1, 8'h00, 342, 400, 1, 334, 400, 2, 0, 1, 0};
        vecs[7] = '{"reset_inv",  1'b0, 8'h00,   0,   0, 1, 320, 400, 3, 0, 0, 0};
        vecs[8] = '{"hit_below",  1'b1, 8'h00, 312, 392, 1, 320, 400, 2, 1, 1, 0};
        vecs[9] = '{"reset2",     1'b0, 8'h00,   0,   0, 1, 320, 400, 3, 0, 0, 0};

        for (int i = 0; i < 10; i++) begin
            Reset   = vecs[i].rst_n;
            keycode = vecs[i].key;
            ismilex = vecs[i].sx;
            ismiley = vecs[i].sy;
            repeat (vecs[i].n) step();
            chk_all(vecs[i].name, vecs[i].ex, vecs[i].ey, vecs[i].el,
                    vecs[i].eh, vecs[i].ei, vecs[i].eg);
        end
        Reset   = 1'b1;
        keycode = 8'h00;
        ismilex = '0;
        ismiley = '0;

        // Left clamp on the odd-start instance: 5 -> 3 -> 2 -> 2
        do_reset();
        chk("clamp.start", int'(s_x), 5);
        keycode = 8'h04;
        step();
        chk("clamp.s1", int'(s_x), 3);
        chk("clamp.main1", int'(eightx), 318);
        step();
        chk("clamp.s2", int'(s_x), 2);
        step();
        chk("clamp.s3", int'(s_x), 2);
        chk("clamp.main3", int'(eightx), 314);
        keycode = 8'h00;

        // Single-frame jump press
        do_reset();
        keycode = 8'h1A;
        step();
        chk("jump1.launch_y", int'(eighty), 400);
        keycode = 8'h00;
        repeat (12) step();
        chk("jump1.apex", int'(eighty), 322);
        repeat (13) step();
        chk("jump1.land", int'(eighty), 400);
        step();
        chk("jump1.stay", int'(eighty), 400);

        // Jump key held through the whole flight: trajectory must be identical
        do_reset();
        keycode = 8'h1A;
        step();
        for (int k = 0; k < 25; k++) begin
            step();
            chk($sformatf("jump_held.E%0d", k + 1), int'(eighty), traj[k]);
        end
        keycode = 8'h00;
        step();
        chk("jump_held.ground", int'(eighty), 400);
        chk("jump_held.x", int'(eightx), 320);

        // Hits, immunity window and game over
        do_reset();
        ismilex = 10'd328;
        ismiley = 10'd400;
        step();
        chk_all("hit1", 320, 400, 2, 1, 1, 0);
        for (int k = 1; k < 60; k++) begin
            step();
            chk($sformatf("immune.f%0d.inv", k), int'(invuln), 1);
            chk($sformatf("immune.f%0d.hit", k), int'(hit), 0);
            chk($sformatf("immune.f%0d.lives", k), int'(lives), 2);
        end
        step();
        chk_all("immune_end", 320, 400, 2, 0, 0, 0);
        step();
        chk_all("hit2", 320, 400, 1, 1, 1, 0);
        repeat (60) step();
        chk_all("immune2_end", 320, 400, 1, 0, 0, 0);
        step();
        chk_all("hit3_dead", 320, 400, 0, 1, 1, 1);
        step();
        chk("dead.hit", int'(hit), 0);
        chk("dead.go", int'(game_over), 1);
        chk("dead.lives", int'(lives), 0);
        keycode = 8'h07;
        repeat (3) step();
        chk("dead.x_frozen", int'(eightx), 320);
        keycode = 8'h1A;
        repeat (3) step();
        chk("dead.y_frozen", int'(eighty), 400);
        chk("dead.x_frozen2", int'(eightx), 320);
        chk("dead.go2", int'(game_over), 1);
        keycode = 8'h00;
        ismilex = '0;
        ismiley = '0;
        do_reset();
        chk_all("dead_reset", 320, 400, 3, 0, 0, 0);

        // Reset asserted mid-rise returns to ground and stays there
        do_reset();
        keycode = 8'h1A;
        step();
        keycode = 8'h00;
        repeat (3) step();
        chk("rise_reset.before", int'(eighty), 367);
        Reset = 1'b0;
        step();
        chk("rise_reset.y", int'(eighty), 400);
        Reset = 1'b1;
        repeat (3) step();
        chk("rise_reset.ground", int'(eighty), 400);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
